// File: rtl/watch_display_scanner_pkg.sv
// Shared constants for the watch display scanner: active-low segment patterns,
// digit slot encoding and the all-off anode pattern.
package watch_display_scanner_pkg;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Slot value doubles as the bit index into an, set_mask and the snapshot
  typedef enum logic [1:0] {
    SLOT_MIN0 = 2'd0,
    SLOT_MIN1 = 2'd1,
    SLOT_HR0  = 2'd2,
    SLOT_HR1  = 2'd3
  } slot_e;

endpackage

// File: rtl/watch_display_scanner_bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
  import watch_display_scanner_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/watch_display_scanner.sv
// Multiplexed 4-digit common-anode display driver with frame snapshot,
// leading-zero suppression, colon blink and set-mode digit blink.
module watch_display_scanner
  import watch_display_scanner_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hr1,
  input  logic [3:0] hr0,
  input  logic [3:0] min1,
  input  logic [3:0] min0,
  input  logic       blank_lz,
  input  logic       set_mode,
  input  logic [3:0] set_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0]   prescale_q, prescale_d;
  slot_e           slot_q, slot_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            phase_q, phase_d;
  logic [3:0][3:0] snap_q, snap_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic       scan_tick;
  logic       frame_wrap;
  logic [3:0] cur_digit;
  logic [6:0] dec_seg;
  logic       lz_blank;
  logic       blink_blank;

  assign scan_tick  = (prescale_q == PW'(SCAN_DIV - 1));
  assign frame_wrap = scan_tick && (slot_q == SLOT_HR1);

  always_comb begin
    prescale_d = scan_tick ? '0 : prescale_q + PW'(1);
    slot_d     = scan_tick ? slot_e'(slot_q + 2'd1) : slot_q;
    frame_d    = frame_q;
    phase_d    = phase_q;
    if (frame_wrap) begin
      if (frame_q == FW'(BLINK_DIV - 1)) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  // All four digits are latched on the same edge so a carry mid-frame never tears
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_snap
      logic [3:0] live_digit;
      if (gi == 0)      begin : g_m0 assign live_digit = min0; end
      else if (gi == 1) begin : g_m1 assign live_digit = min1; end
      else if (gi == 2) begin : g_h0 assign live_digit = hr0;  end
      else              begin : g_h1 assign live_digit = hr1;  end
      assign snap_d[gi] = frame_wrap ? live_digit : snap_q[gi];
    end
  endgenerate

  assign cur_digit = snap_q[slot_q];

  bcd_to_7seg u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  assign lz_blank    = (slot_q == SLOT_HR1) && blank_lz && (snap_q[SLOT_HR1] == 4'd0);
  assign blink_blank = set_mode && phase_q && set_mask[slot_q];

  // The tick cycle loads an all-off pattern, giving one dark cycle between digits
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!scan_tick) begin
      an_d  = ~(4'b0001 << slot_q);
      seg_d = (lz_blank || blink_blank) ? SEG_OFF : dec_seg;
      dp_d  = ~((slot_q == SLOT_HR0) && (!phase_q || set_mode));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_q <= '0;
      slot_q     <= SLOT_MIN0;
      frame_q    <= '0;
      phase_q    <= 1'b0;
      snap_q     <= '0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
    end else begin
      prescale_q <= prescale_d;
      slot_q     <= slot_d;
      frame_q    <= frame_d;
      phase_q    <= phase_d;
      snap_q     <= snap_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_watch_display_scanner.sv
// Bench for watch_display_scanner: cycle-level model derived from elapsed
// cycle count plus directed literal checks.
module tb_watch_display_scanner;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;
  localparam int FRAME     = 4 * SCAN_DIV;
  localparam int DEPTH     = 1024;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] hr1 = 4'd1, hr0 = 4'd2, min1 = 4'd3, min0 = 4'd4;
  logic       blank_lz = 1'b0, set_mode = 1'b0;
  logic [3:0] set_mask = 4'b0000;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  watch_display_scanner #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .hr1      (hr1),
    .hr0      (hr0),
    .min1     (min1),
    .min0     (min0),
    .blank_lz (blank_lz),
    .set_mode (set_mode),
    .set_mask (set_mask),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] h1, h0, m1, m0;
    logic       lz, sm;
    logic [3:0] mask;
  } rec_t;

  rec_t       inp [0:DEPTH-1];
  logic [6:0] seg_tab [0:15];
  int         m_cnt = 0;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (m=%0d): got %h expected %h", name, m_cnt, act, exp);
    end
  endtask

  // Edge counter since reset release; inputs seen at edge k are stored in inp[k]
  always @(posedge clk or posedge reset) begin
    if (reset) m_cnt = 0;
    else begin
      m_cnt = m_cnt + 1;
      if (m_cnt < DEPTH)
        inp[m_cnt] = {hr1, hr0, min1, min0, blank_lz, set_mode, set_mask};
    end
  end

  // Outputs after m edges reflect cycle p=m-1: slot=(p/SCAN_DIV)%4, completed frames=p/FRAME
  task automatic model(input int m, output logic [3:0] e_an, output logic [6:0] e_seg,
                       output logic e_dp);
    int         p, s, f, phase;
    rec_t       r, snap;
    logic [3:0] d;
    logic       blank;
    e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
    if (m == 0) return;
    p = m - 1;
    if (p % SCAN_DIV == SCAN_DIV - 1) return;
    s     = (p / SCAN_DIV) % 4;
    f     = p / FRAME;
    phase = (f / BLINK_DIV) % 2;
    r     = inp[m];
    snap  = (f == 0) ? '0 : inp[FRAME * f];
    case (s)
      0: d = snap.m0;
      1: d = snap.m1;
      2: d = snap.h0;
      default: d = snap.h1;
    endcase
    blank = (s == 3 && r.lz && snap.h1 == 4'd0) || (r.sm && phase == 1 && r.mask[s]);
    e_an  = 4'b1111 & ~(4'b0001 << s);
    e_seg = blank ? 7'h7F : seg_tab[d];
    e_dp  = (s == 2 && (phase == 0 || r.sm)) ? 1'b0 : 1'b1;
  endtask

  always @(negedge clk) begin
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    if (!reset && m_cnt < DEPTH) begin
      model(m_cnt, e_an, e_seg, e_dp);
      check("model_an",  {3'b000, an},  {3'b000, e_an});
      check("model_seg", seg, e_seg);
      check("model_dp",  {6'b0, dp},   {6'b0, e_dp});
    end
  end

  task automatic wait_m(input int target);
    int k = 0;
    while (m_cnt != target && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (m_cnt != target) begin
      tests++;
      fails++;
      $display("FAIL wait_m: timed out at m=%0d waiting for %0d", m_cnt, target);
    end
  endtask

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h3F;

    repeat (2) @(negedge clk);
    check("reset_an",  {3'b000, an}, 7'h0F);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp",  {6'b0, dp}, 7'h01);
    reset = 1'b0;

    // Scan order and break-before-make gaps; first frame shows zeros
    wait_m(1);  check("first_min0_an",  {3'b000, an}, 7'h0E); check("first_min0_seg", seg, 7'h40);
    wait_m(4);  check("gap_an",  {3'b000, an}, 7'h0F); check("gap_seg", seg, 7'h7F);
    wait_m(5);  check("min1_an", {3'b000, an}, 7'h0D);
    wait_m(9);  check("hr0_an",  {3'b000, an}, 7'h0B);
    wait_m(10); check("colon_dp", {6'b0, dp}, 7'h00);
    wait_m(13); check("hr1_an",  {3'b000, an}, 7'h07);
    wait_m(18); check("f1_min0_seg", seg, 7'h19); check("f1_min0_an", {3'b000, an}, 7'h0E);
    wait_m(20); min0 = 4'd5;
    wait_m(22); check("f1_min1_seg", seg, 7'h30);
    wait_m(30); check("f1_hr1_seg", seg, 7'h79);

    // Snapshot isolation: min0 changed during hr0 slot shows only next frame
    wait_m(34); check("f2_min0_5", seg, 7'h12);
    wait_m(41); min0 = 4'd6;
    wait_m(42); check("colon_off_dp", {6'b0, dp}, 7'h01); check("f2_hr0_seg", seg, 7'h24);
    wait_m(50); check("f3_min0_6", seg, 7'h02);

    // Leading-zero suppression, then dash for non-BCD
    wait_m(52); hr1 = 4'd0; blank_lz = 1'b1;
    wait_m(78); check("lz_seg", seg, 7'h7F); check("lz_an", {3'b000, an}, 7'h07);
    wait_m(80); blank_lz = 1'b0; min1 = 4'hC;
    wait_m(94);  check("nolz_seg", seg, 7'h40);
    wait_m(102); check("dash_seg", seg, 7'h3F);

    // Set mode: minute digits blink, hours steady, colon steady
    wait_m(104); set_mode = 1'b1; set_mask = 4'b0011;
    wait_m(130); check("set_min0_on",  seg, 7'h02);
    wait_m(162); check("set_min0_off", seg, 7'h7F);
    wait_m(170); check("set_dp", {6'b0, dp}, 7'h00); check("set_hr0_seg", seg, 7'h24);
    wait_m(182); check("set_dash_off", seg, 7'h7F);

    // Asynchronous reset mid-slot
    wait_m(186); check("pre_reset_an", {3'b000, an}, 7'h0B);
    #2 reset = 1'b1;
    #1;
    check("async_an",  {3'b000, an}, 7'h0F);
    check("async_seg", seg, 7'h7F);
    check("async_dp",  {6'b0, dp}, 7'h01);
    @(negedge clk);
    reset = 1'b0;
    wait_m(1); check("restart_an", {3'b000, an}, 7'h0E); check("restart_seg", seg, 7'h40);
    wait_m(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
